// File: rtl/xor_pkg.sv
// xor_pkg
// Shared definitions for the XOR checksum unit: FSM state encoding and the
// default operand geometry used when the top is instantiated without
// parameter overrides.
package xor_pkg;

    localparam int XOR_WIDTH_DEF = 8;
    localparam int XOR_LANES_DEF = 2;

    typedef enum logic [0:0] {
        XOR_IDLE  = 1'b0,
        XOR_ACCUM = 1'b1
    } xor_state_e;

endpackage

// File: rtl/xor_lane_reduce.sv
// xor_lane_reduce
// Purely combinational XOR reduction of LANES operands of WIDTH bits each.
// Ports:
//   in_data  [LANES*WIDTH] - packed operands, lane k at [k*WIDTH +: WIDTH]
//   lane_xor [WIDTH]       - XOR of all lanes
module xor_lane_reduce #(
    parameter int WIDTH = xor_pkg::XOR_WIDTH_DEF,
    parameter int LANES = xor_pkg::XOR_LANES_DEF
) (
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]       lane_xor
);

    always_comb begin
        lane_xor = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_xor = lane_xor ^ in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/xor_checksum_unit.sv
// xor_checksum_unit
// Registered XOR engine between a valid/ready producer and consumer. Each
// beat carries LANES operands that are XOR-reduced. Beat mode returns one
// result per beat; accumulate mode folds a multi-beat packet into a single
// checksum delivered after the in_last beat. Acts as a one-entry output
// register stage with full-throughput handshake.
//
// Optional feature macro: XOR_PARITY_EN adds out_parity, the XOR of the
// result bits, registered alongside out_data.
//
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid / in_ready  - producer handshake
//   in_data              - LANES*WIDTH packed operands
//   in_last              - final beat of an accumulate packet
//   mode                 - 0 beat, 1 accumulate (sampled on first beat only)
//   out_valid / out_ready- consumer handshake
//   out_data             - XOR result
//   out_parity           - parity of out_data (XOR_PARITY_EN only)
//
// State | Meaning
// ------+---------------------------------------------
// IDLE  | no packet open; beats produce results directly
// ACCUM | accumulate packet open, acc_q holds partial XOR
module xor_checksum_unit
    import xor_pkg::*;
#(
    parameter int WIDTH = XOR_WIDTH_DEF,
    parameter int LANES = XOR_LANES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef XOR_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    xor_state_e        state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  lane_xor;
    logic [WIDTH-1:0]  result;
    logic              produce;
    logic              accept;
    logic              deliver;

    xor_lane_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .in_data  (in_data),
        .lane_xor (lane_xor)
    );

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    // Accumulate mode is implied by being in ACCUM, so no separate mode
    // register is needed; the mode input is simply not consulted there.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        produce     = 1'b0;
        result      = acc_q ^ lane_xor;

        if (deliver) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                XOR_IDLE: begin
                    if (!mode || in_last) begin
                        produce = 1'b1;
                        result  = lane_xor;
                    end else begin
                        acc_d   = lane_xor;
                        state_d = XOR_ACCUM;
                    end
                end
                XOR_ACCUM: begin
                    if (in_last) begin
                        produce = 1'b1;
                        acc_d   = '0;
                        state_d = XOR_IDLE;
                    end else begin
                        acc_d   = acc_q ^ lane_xor;
                    end
                end
                default: begin
                    state_d = XOR_IDLE;
                    acc_d   = '0;
                end
            endcase
        end

        // A new result overrides the drain above, so deliver+produce keeps
        // out_valid high with fresh data.
        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= XOR_IDLE;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef XOR_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity_q <= 1'b0;
        end else if (produce) begin
            out_parity_q <= ^result;
        end
    end

    assign out_parity = out_parity_q;
`endif

endmodule

// File: doc/xor_checksum_unit.md
# xor_checksum_unit

Parametrised, registered XOR engine: the sequential successor to the single-bit XOR gate. Each beat carries LANES operands of WIDTH bits, and the block reduces them by XOR. In beat mode it returns one result per beat. In accumulate mode it folds a multi-beat packet into one XOR checksum. It sits between a valid/ready producer and consumer as a one-entry registered stage.

## Interface
- WIDTH, 8, bits per operand lane and per result
- LANES, 2, operands XORed per beat (≥1)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  LANES*WIDTH  operands; lane k = in_data[k*WIDTH +: WIDTH]
- in_last  input  1  final beat of packet (used in accumulate mode only)
- mode  input  1  0 = beat mode, 1 = accumulate mode; sampled on first beat of a packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  XOR result
- out_parity  output  1  even parity of out_data (only with XOR_PARITY_EN)

One clock; reset is asynchronous and active-low.

## Operation
- lane_xor = XOR of all LANES lanes of in_data (combinational).
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- in_ready = !out_valid || out_ready in all states, including a combinational pass-through of out_ready.
- FSM states: IDLE (no packet open) and ACCUM (packet open, acc holds partial XOR).
- IDLE, accept, mode=0: out_data <= lane_xor, out_valid <= 1, stay IDLE.
- IDLE, accept, mode=1, in_last=1: behaves as beat mode; out_data <= lane_xor.
- IDLE, accept, mode=1, in_last=0: acc <= lane_xor, latch mode, go to ACCUM. No output.
- ACCUM, accept, in_last=0: acc <= acc ^ lane_xor.
- ACCUM, accept, in_last=1: out_data <= acc ^ lane_xor, out_valid <= 1, acc <= 0, go to IDLE.
- The mode input is ignored while in ACCUM.
- Non-final beats in ACCUM are still gated by in_ready. This keeps the handshake uniform.
- Deliver with no new result: out_valid <= 0 and out_data holds its value.
- Deliver and a result-producing accept in the same cycle: out_valid stays 1 and out_data takes the new value. No bubble and no loss.
- Reset values: out_valid 0, out_data 0, out_parity 0, acc 0, state IDLE. in_ready is 1 during and after reset.
- Reset mid-packet discards the partial acc. The next accepted beat starts a new packet.

## Timing
- Latency: result visible on out_data/out_valid one cycle after the accepting edge of a beat-mode beat or a final beat.
- Throughput: one beat per cycle while out_ready=1.
- With out_valid=1 and out_ready=0: out_data and out_parity hold stable and in_ready=0.
- No combinational path from in_data to outputs.

## Configuration
- XOR_PARITY_EN defined: the out_parity port exists. It is registered together with out_data as ^(result), so it updates on the same edge.
- XOR_PARITY_EN undefined: the port and its flop are absent. All other behaviour is identical.

## Structure
- Package xor_pkg holds:
  - the state enum typedef (XOR_IDLE, XOR_ACCUM);
  - default WIDTH/LANES localparams.
- Sub-module xor_lane_reduce (parameters WIDTH, LANES) is the purely combinational lane_xor tree. It is instantiated once.

## Test plan
All scenarios use WIDTH=8 and LANES=2; lane 0 is listed first.
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0x00, in_ready=1; after release, no output until a beat is accepted.
- Beat mode: mode=0, lanes {0xA5,0x3C}, in_valid=1 for one cycle, out_ready=1 -> next cycle out_data=0x99, out_valid=1; with XOR_PARITY_EN, out_parity=0.
- Accumulate:
  - Stimulus: mode=1, beats {0x01,0x02}, {0x04,0x08}, then {0xF0,0x00} with in_last=1.
  - Expected: out_valid=0 until one cycle after the last beat, then out_data=0xFF.
  - Follow-up: a mode=0 beat {0x07,0x00} -> out_data=0x07, out_parity=1.
- Backpressure:
  - Stimulus: out_ready=0 after result 0x99, in_valid held with {0x0F,0x00}.
  - Expected: in_ready=0 and out_data stays 0x99 for 5 cycles.
  - Then raise out_ready: 0x99 delivers and 0x0F appears the next cycle with no gap.
- Reset mid-packet: mode=1, accept {0xAA,0x00} (in_last=0), assert rst_n low for 1 cycle, then mode=1 single beat {0x11,0x00} with in_last=1 -> out_data=0x11, not 0xBB.
- Single-beat accumulate and mode glitch: mode=1 with in_last on the first beat {0x30,0x03} -> out_data=0x33; toggling mode during a 3-beat ACCUM packet does not change its result.
